// File: rtl/edge_pair_monitor.sv
// ----------------------------------------------------------------------------
// edge_pair_monitor
//
// Purpose:
//    Watches N_CH independent trigger/response pairs. Each rising edge of a[i]
//    opens a window in which a rising edge of b[i] must appear. The window
//    covers the trigger cycle itself plus MAX_DLY further cycles. A response
//    inside the window is a pass. A window that expires, or is pre-empted by a
//    new trigger, is a fail. Decisions come out as one-cycle pulses. They also
//    feed a sticky per-channel error flag and two saturating totals.
//
// Parameters:
//    N_CH     number of a/b channels (1..16)
//    MAX_DLY  cycles allowed from rise of a to rise of b (0 = same cycle)
//    CNT_W    width of the pass/fail totals
//
// Ports:
//    clk         clock, everything on its rising edge
//    rst_n       synchronous active-low reset
//    en          monitor enable; low forces every channel idle
//    a, b        per-channel trigger / response levels
//    clr_err     clears err_sticky and both totals
//    busy        channel is waiting for a response (ARMED)
//    pass_pulse  one-cycle pass indication per channel
//    fail_pulse  one-cycle fail indication per channel
//    err_sticky  latched fail flag per channel
//    pass_cnt    saturating total of passes over all channels
//    fail_cnt    saturating total of fails over all channels
// ----------------------------------------------------------------------------
module edge_pair_monitor #(
   parameter int N_CH    = 4,
   parameter int MAX_DLY = 0,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [N_CH-1:0]   a,
   input  logic [N_CH-1:0]   b,
   input  logic              clr_err,
   output logic [N_CH-1:0]   busy,
   output logic [N_CH-1:0]   pass_pulse,
   output logic [N_CH-1:0]   fail_pulse,
   output logic [N_CH-1:0]   err_sticky,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt
);

   // The timer needs at least one bit, even when MAX_DLY is 0 and it is never used.
   localparam int TMR_W = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;
   // ARMED is entered one cycle after the trigger. A load of MAX_DLY-1 therefore
   // makes the timer read 0 exactly in the last cycle of the window.
   localparam logic [TMR_W-1:0] TMR_LOAD = (MAX_DLY > 0) ? TMR_W'(MAX_DLY - 1) : '0;
   localparam int PC_W  = $clog2(N_CH + 1);
   localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } state_t;

   // Decisions made in the current cycle, one bit per channel.
   logic [N_CH-1:0]  pass_dec;
   logic [N_CH-1:0]  fail_dec;

   logic [N_CH-1:0]  pass_pulse_reg;
   logic [N_CH-1:0]  fail_pulse_reg;
   logic [N_CH-1:0]  err_sticky_reg;
   logic [CNT_W-1:0] pass_cnt_reg;
   logic [CNT_W-1:0] fail_cnt_reg;

   // ------------------------------------------------------------------------
   // Per-channel edge detect and window FSM
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic             a_q_reg;
         logic             b_q_reg;
         state_t           state_reg;
         state_t           state_next;
         logic [TMR_W-1:0] timer_reg;
         logic [TMR_W-1:0] timer_next;
         logic             rose_a;
         logic             rose_b;
         logic             pass_d;
         logic             fail_d;

         assign rose_a = a[gi] & ~a_q_reg;
         assign rose_b = b[gi] & ~b_q_reg;

         always_comb begin
            state_next = state_reg;
            timer_next = timer_reg;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            if (!en) begin
               state_next = IDLE;
               timer_next = '0;
            end else begin
               case (state_reg)
                  IDLE: begin
                     if (rose_a) begin
                        if (rose_b) begin
                           pass_d = 1'b1;
                        end else if (MAX_DLY == 0) begin
                           fail_d = 1'b1;
                        end else begin
                           state_next = ARMED;
                           timer_next = TMR_LOAD;
                        end
                     end
                  end
                  ARMED: begin
                     if (rose_b) begin
                        // The response settles the pending trigger. A trigger in the
                        // same cycle opens a new window.
                        pass_d = 1'b1;
                        if (rose_a) begin
                           timer_next = TMR_LOAD;
                        end else begin
                           state_next = IDLE;
                           timer_next = '0;
                        end
                     end else if (rose_a) begin
                        // A new trigger arrived first: the old one fails and the
                        // window restarts for the new one.
                        fail_d     = 1'b1;
                        timer_next = TMR_LOAD;
                     end else if (timer_reg == '0) begin
                        fail_d     = 1'b1;
                        state_next = IDLE;
                     end else begin
                        timer_next = timer_reg - TMR_W'(1);
                     end
                  end
                  default: begin
                     state_next = IDLE;
                     timer_next = '0;
                  end
               endcase
            end
         end

         // The edge registers follow a/b even while disabled. This keeps a level
         // that is already high at enable from counting as a rise.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               a_q_reg   <= 1'b0;
               b_q_reg   <= 1'b0;
               state_reg <= IDLE;
               timer_reg <= '0;
            end else begin
               a_q_reg   <= a[gi];
               b_q_reg   <= b[gi];
               state_reg <= state_next;
               timer_reg <= timer_next;
            end
         end

         assign pass_dec[gi] = pass_d;
         assign fail_dec[gi] = fail_d;
         assign busy[gi]     = (state_reg == ARMED);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Totals
   // ------------------------------------------------------------------------
   function automatic logic [PC_W-1:0] popcount(input logic [N_CH-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < N_CH; i++) begin
         n = n + PC_W'(v[i]);
      end
      return n;
   endfunction

   // The sum is one bit wider than either operand, so the compare sees the true total.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                input logic [PC_W-1:0]  inc);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(base) + SUM_W'(inc);
      if (sum > SUM_W'(CNT_MAX)) begin
         return CNT_MAX;
      end
      return sum[CNT_W-1:0];
   endfunction

   // A clear only drops the old contents. Decisions from the same cycle still land.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass_pulse_reg <= '0;
         fail_pulse_reg <= '0;
         err_sticky_reg <= '0;
         pass_cnt_reg   <= '0;
         fail_cnt_reg   <= '0;
      end else begin
         pass_pulse_reg <= pass_dec;
         fail_pulse_reg <= fail_dec;
         err_sticky_reg <= (clr_err ? {N_CH{1'b0}} : err_sticky_reg) | fail_dec;
         pass_cnt_reg   <= sat_add(clr_err ? {CNT_W{1'b0}} : pass_cnt_reg, popcount(pass_dec));
         fail_cnt_reg   <= sat_add(clr_err ? {CNT_W{1'b0}} : fail_cnt_reg, popcount(fail_dec));
      end
   end

   assign pass_pulse = pass_pulse_reg;
   assign fail_pulse = fail_pulse_reg;
   assign err_sticky = err_sticky_reg;
   assign pass_cnt   = pass_cnt_reg;
   assign fail_cnt   = fail_cnt_reg;

endmodule

// File: doc/edge_pair_monitor.md
EDGE_PAIR_MONITOR -- requirements
Module: edge_pair_monitor

Interface
REQ-001 Parameter N_CH, default 4, number of independent a/b channels (1..16).
REQ-002 Parameter MAX_DLY, default 0, max cycles from rise of a to rise of b (0 = same cycle; range 0..15).
REQ-003 Parameter CNT_W, default 8, width of pass/fail counters.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 en  input  1  monitor enable.
REQ-007 a  input  N_CH  trigger signals, one per channel.
REQ-008 b  input  N_CH  response signals, one per channel.
REQ-009 clr_err  input  1  clear sticky errors and counters.
REQ-010 busy  output  N_CH  channel is ARMED (awaiting rise of b).
REQ-011 pass_pulse  output  N_CH  one-cycle pass indication per channel.
REQ-012 fail_pulse  output  N_CH  one-cycle fail indication per channel.
REQ-013 err_sticky  output  N_CH  latched fail flag per channel.
REQ-014 pass_cnt  output  CNT_W  total passes, all channels, saturating.
REQ-015 fail_cnt  output  CNT_W  total fails, all channels, saturating.

Function
REQ-016 Per channel, a_q/b_q register previous a/b every cycle regardless of en; rose_a = a & ~a_q, rose_b = b & ~b_q.
REQ-017 Per-channel FSM states IDLE and ARMED, plus timer of width clog2(MAX_DLY+1), min 1.
REQ-018 IDLE, rose_a & rose_b -> pass decision, stay IDLE.
REQ-019 IDLE, rose_a & ~rose_b, MAX_DLY==0 -> fail decision, stay IDLE.
REQ-020 IDLE, rose_a & ~rose_b, MAX_DLY>0 -> ARMED, timer loaded with MAX_DLY-1.
REQ-021 IDLE, rose_b without rose_a -> no decision (b alone is not an error).
REQ-022 ARMED, rose_b -> pass decision for pending trigger; if rose_a same cycle, re-arm with timer MAX_DLY-1, else -> IDLE.
REQ-023 ARMED, ~rose_b, rose_a -> fail decision for pending trigger, re-arm with timer MAX_DLY-1.
REQ-024 ARMED, ~rose_b, ~rose_a, timer==0 -> fail decision, -> IDLE; else timer decrements.
REQ-025 Net window: rise of b accepted in cycles 0..MAX_DLY relative to the cycle rose_a is seen.
REQ-026 Decisions are registered: pass_pulse/fail_pulse high exactly one cycle, the cycle after the decision cycle.
REQ-027 busy is the registered ARMED state.
REQ-028 err_sticky[i] sets with fail_pulse[i]; held until clr_err or reset.
REQ-029 Counters add popcount of the cycle's pass (resp. fail) decisions, saturating at 2^CNT_W-1, no wrap.
REQ-030 clr_err: err_sticky and counters cleared; same-cycle decisions still apply (counter loads that cycle's popcount, sticky sets on that cycle's fail).
REQ-031 en=0: all FSMs forced IDLE, timers cleared, no decisions; edge registers keep tracking, so a level already high at enable is not a rise.
REQ-032 en deasserted while ARMED: pending trigger discarded, no pulse.
REQ-033 Channels fully independent; simultaneous decisions on all channels supported in one cycle.

Reset
REQ-034 rst_n=0 at posedge clk: a_q, b_q, FSMs (IDLE), timers, busy, pass_pulse, fail_pulse, err_sticky, pass_cnt, fail_cnt all 0.
REQ-035 Reset mid-operation discards pending triggers with no pulse; a high on first post-reset cycle counts as rise (a_q=0).

Verification
REQ-036 MAX_DLY=0, ch0 a and b rise same cycle (t=30) -> pass_pulse[0] one cycle at next edge, pass_cnt=1, fail_cnt=0.
REQ-037 MAX_DLY=0, ch1 a rises, b stays 0 -> fail_pulse[1] next cycle, err_sticky[1]=1, fail_cnt=1.
REQ-038 MAX_DLY=3, ch2 b rises 3 cycles after a -> pass, busy[2] high 3 cycles; b rises 4 cycles after -> fail at timeout, none later.
REQ-039 MAX_DLY=3, ch0 a rises twice 2 cycles apart, no b -> fail on second rise, re-arm, second fail 3 cycles later; fail_cnt=2.
REQ-040 CNT_W=2, four channels fail same cycle -> fail_cnt saturates at 3; then clr_err with one pass that cycle -> pass_cnt=1, fail_cnt=0, err_sticky=0.
REQ-041 en dropped while ARMED, then rst_n pulsed mid-window -> no pulses, busy=0, all outputs 0 after reset.
